// File: rtl/gnss_sample_capture_periph.sv
// GNSS IF sample capture peripheral: packs 2-bit samples into 32-bit words, FIFO, register-read drain.
// Optional macro GNSS_CAPTURE_SAMPLE_CNT_EN implements the SAMPLE_CNT counter at offset 0xC.
module gnss_sample_capture_periph #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IRQ_LEVEL  = 8
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        sample_valid,
  input  logic [1:0]  sample_data,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_CNT    = 2'd3
  } reg_sel_e;

  reg_sel_e    sel;
  logic        commit, is_wr, is_rd;
  logic        flush, ovf_clr, ctrl_wr;
  logic        en, irq_en, ovf;
  logic [3:0]  idx;
  logic [31:0] pack_word, push_word;
  logic        pack_push, fifo_wr, pop;
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level, level_nxt;
  logic        empty, full, lvl_hit;
  logic [8:0]  level9;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [31:0] cnt_rd, rd_mux;
  logic        unused_bits;

  assign sel     = reg_sel_e'(mem_addr[3:2]);
  assign commit  = mem_ready & mem_valid;
  assign is_wr   = commit & (|mem_wstrb);
  assign is_rd   = commit & ~(|mem_wstrb);
  assign ctrl_wr = is_wr && (sel == REG_CTRL) && mem_wstrb[0];
  assign flush   = ctrl_wr && mem_wdata[1];
  assign ovf_clr = is_wr && (sel == REG_STATUS) && mem_wstrb[2] && mem_wdata[16];

  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign lvl_hit = (level >= LW'(IRQ_LEVEL));
  assign level9  = 9'(level);

  assign pop       = is_rd && (sel == REG_DATA) && !empty;
  assign pack_push = en && sample_valid && (idx == 4'd15);
  assign push_word = {sample_data, pack_word[29:0]};
  // Pop frees the slot first, so a full FIFO still accepts a push in the same cycle.
  assign fifo_wr   = pack_push && (!full || pop);

  always_comb begin
    level_nxt = level;
    if (fifo_wr && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !fifo_wr)
      level_nxt = level - LW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      irq       <= 1'b0;
      en        <= 1'b0;
      irq_en    <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      pack_word <= '0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
    end else begin
      mem_ready <= mem_valid & ~mem_ready;
      irq       <= irq_en & (lvl_hit | ovf);
      if (ctrl_wr) begin
        en     <= mem_wdata[0];
        irq_en <= mem_wdata[2];
      end
      if (flush) begin
        idx       <= '0;
        pack_word <= '0;
        wptr      <= '0;
        rptr      <= '0;
        level     <= '0;
      end else begin
        if (!en) begin
          idx       <= '0;
          pack_word <= '0;
        end else if (sample_valid) begin
          pack_word[{idx, 1'b0} +: 2] <= sample_data;
          idx                         <= idx + 4'd1;
        end
        if (pop)     rptr <= rptr + AW'(1);
        if (fifo_wr) wptr <= wptr + AW'(1);
        level <= level_nxt;
      end
      if (pack_push && full && !pop && !flush)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst_n && !flush && fifo_wr)
      fifo_mem[wptr] <= push_word;
  end

`ifdef GNSS_CAPTURE_SAMPLE_CNT_EN
  logic [31:0] sample_cnt;

  always_ff @(posedge sys_clk) begin
    if (!rst_n)
      sample_cnt <= '0;
    else if (en && sample_valid)
      sample_cnt <= sample_cnt + 32'd1;
  end

  assign cnt_rd = sample_cnt;
`else
  assign cnt_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL:   rd_mux = {29'b0, irq_en, 1'b0, en};
      REG_STATUS: rd_mux = {15'b0, ovf, 2'b0, full, empty, 3'b0, level9};
      REG_DATA:   if (!empty) rd_mux = fifo_mem[rptr];
      REG_CNT:    rd_mux = cnt_rd;
      default:    rd_mux = '0;
    endcase
  end

  assign mem_rdata = mem_ready ? rd_mux : '0;

  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:17], mem_wdata[15:3]};

endmodule

// File: tb/tb_gnss_sample_capture_periph.sv
// Directed self-checking bench for gnss_sample_capture_periph (FIFO_DEPTH=16, IRQ_LEVEL=8).
module tb_gnss_sample_capture_periph;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        sample_valid;
  logic [1:0]  sample_data;
  logic        irq;

  int tests  = 0;
  int failed = 0;
  int exp_cnt = 0;
  logic [31:0] d;

  localparam logic [31:0] A_CTRL = 32'h0, A_STAT = 32'h4, A_DATA = 32'h8, A_CNT = 32'hC;
  localparam logic [31:0] WORD_E4 = 32'hE4E4_E4E4;

  gnss_sample_capture_periph #(.FIFO_DEPTH(16), .IRQ_LEVEL(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .sample_valid(sample_valid), .sample_data(sample_data), .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the commit edge.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output logic [31:0] rdata);
    int cyc;
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge sys_clk); #1;
      cyc++;
    end while (!mem_ready && cyc < 8);
    check("ack_latency", 32'(cyc), 32'd1);
    rdata = mem_rdata;
    @(posedge sys_clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    bus(addr, 32'h0, 4'h0, r);
    check(tag, r, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    bus(addr, data, strb, r);
  endtask

  // mode 0: values 0,1,2,3 repeating from 0; mode 1: constant 3
  task automatic feed(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = (mode == 0) ? 2'(i % 4) : 2'd3;
      @(posedge sys_clk); #1;
    end
    sample_valid = 1'b0;
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef GNSS_CAPTURE_SAMPLE_CNT_EN
    return 32'(exp_cnt);
`else
    return 32'h0;
`endif
  endfunction

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    sample_valid = 1'b0; sample_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Reset register values
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_STAT, 32'h0000_1000, "rst_status");
    rd(A_DATA, 32'h0, "rst_data");
    rd(A_CNT,  cnt_exp(), "rst_cnt");
    check("idle_rdata", mem_rdata, 32'd0);

    // One packed word
    wr(A_CTRL, 32'h1, 4'h1);
    rd(A_CTRL, 32'h1, "ctrl_en");
    feed(16, 0); exp_cnt += 16;
    rd(A_STAT, 32'h0000_0001, "one_word_level");
    rd(A_DATA, WORD_E4, "one_word_data");
    rd(A_DATA, 32'h0, "empty_data");
    rd(A_STAT, 32'h0000_1000, "after_pop_status");
    rd(A_CNT, cnt_exp(), "cnt_16");

    // Overflow and OVF clear
    feed(17 * 16, 0); exp_cnt += 17 * 16;
    rd(A_STAT, 32'h0001_2010, "ovf_status");
    wr(A_DATA, 32'h1234_5678, 4'hF);
    rd(A_STAT, 32'h0001_2010, "data_write_ignored");
    wr(A_STAT, 32'h0001_0000, 4'h4);
    rd(A_STAT, 32'h0000_2010, "ovf_cleared");
    rd(A_CNT, cnt_exp(), "cnt_288");

    // Level interrupt
    wr(A_CTRL, 32'h3, 4'h1);
    wr(A_CTRL, 32'h5, 4'h1);
    rd(A_STAT, 32'h0000_1000, "flush_empty");
    feed(7 * 16, 0); exp_cnt += 7 * 16;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    check("irq_7_words", 32'(irq), 32'd0);
    feed(16, 0); exp_cnt += 16;
    check("irq_registered", 32'(irq), 32'd0);
    @(posedge sys_clk); #1;
    check("irq_8_words", 32'(irq), 32'd1);
    rd(A_DATA, WORD_E4, "irq_pop_data");
    @(posedge sys_clk); #1;
    check("irq_after_pop", 32'(irq), 32'd0);

    // FLUSH discards a partial word
    wr(A_CTRL, 32'h3, 4'h1);
    feed(5, 1); exp_cnt += 5;
    wr(A_CTRL, 32'h3, 4'h1);
    feed(16, 0); exp_cnt += 16;
    rd(A_STAT, 32'h0000_0001, "flush_level");
    rd(A_DATA, WORD_E4, "flush_word");
    rd(A_CNT, cnt_exp(), "cnt_after_flush");

    // Full FIFO: pop commits on the same edge as a push
    wr(A_CTRL, 32'h3, 4'h1);
    feed(16 * 16, 0);
    rd(A_STAT, 32'h0000_2010, "full_status");
    feed(15, 0);
    mem_addr = A_DATA; mem_wdata = '0; mem_wstrb = '0; mem_valid = 1'b1;
    @(posedge sys_clk); #1;
    check("race_ready", 32'(mem_ready), 32'd1);
    check("race_data", mem_rdata, WORD_E4);
    sample_valid = 1'b1; sample_data = 2'd3;
    @(posedge sys_clk); #1;
    sample_valid = 1'b0; mem_valid = 1'b0;
    rd(A_STAT, 32'h0000_2010, "race_status");

    // Reset drops a pending read
    mem_addr = A_DATA; mem_wstrb = '0; mem_valid = 1'b1; rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check("rst_pending_ready0", 32'(mem_ready), 32'd0);
    @(posedge sys_clk); #1;
    check("rst_pending_ready1", 32'(mem_ready), 32'd0);
    mem_valid = 1'b0; rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("rst_pending_ready2", 32'(mem_ready), 32'd0);
    rd(A_STAT, 32'h0000_1000, "post_rst_status");
    rd(A_CTRL, 32'h0, "post_rst_ctrl");
    check("post_rst_irq", 32'(irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
